// File: rtl/register_file_32x32.sv
// 32x32 MIPS register file: one-hot write port from the decoder, two combinational read ports with write bypass.
// Latency: reads 0 cycles, writes commit on the rising edge; no backpressure, every legal write is accepted.
module register_file_32x32 #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       E,
  input  logic [DATA_W-1:0] PW,
  input  logic [4:0]        SA,
  input  logic [4:0]        SB,
  output logic [DATA_W-1:0] PA,
  output logic [DATA_W-1:0] PB,
  output logic              onehot_err,
  output logic [CNT_W-1:0]  wr_count
);

  logic [DATA_W-1:0] regs [0:31];
  logic              e_onehot;
  logic              e_multi;
  logic [4:0]        wr_idx;

  // E & (E-1) clears the lowest set bit; anything left means two or more bits were set.
  assign e_multi  = (E & (E - 32'd1)) != 32'd0;
  assign e_onehot = (E != 32'd0) && !e_multi;

  always_comb begin
    wr_idx = 5'd0;
    for (int i = 0; i < 32; i++) begin
      if (E[i]) wr_idx = 5'(i);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      onehot_err <= 1'b0;
      wr_count   <= '0;
    end else begin
      if (e_onehot) begin
        // A write to $zero is a legal issue: it counts but leaves the register alone.
        if (wr_idx != 5'd0) regs[wr_idx] <= PW;
        if (wr_count != {CNT_W{1'b1}}) wr_count <= wr_count + 1'b1;
      end else if (e_multi) begin
        onehot_err <= 1'b1;
      end
    end
  end

  always_comb begin
    PA = regs[SA];
    if (SA == 5'd0) PA = '0;
    else if (e_onehot && wr_idx == SA) PA = PW;
  end

  always_comb begin
    PB = regs[SB];
    if (SB == 5'd0) PB = '0;
    else if (e_onehot && wr_idx == SB) PB = PW;
  end

endmodule

// File: tb/tb_register_file_32x32.sv
// Randomized bench for register_file_32x32 against a behavioural model; a second instance uses a 4-bit counter.
module tb_register_file_32x32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] E = '0;
  logic [31:0] PW = '0;
  logic [4:0]  SA = '0;
  logic [4:0]  SB = '0;
  logic [31:0] PA, PB, PA4, PB4;
  logic        err, err4;
  logic [15:0] cnt;
  logic [3:0]  cnt4;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [32];
  logic        ref_err;
  int          ref_cnt, ref_cnt4;

  always #5 clk = ~clk;

  register_file_32x32 dut (
    .clk(clk), .reset(reset), .E(E), .PW(PW), .SA(SA), .SB(SB),
    .PA(PA), .PB(PB), .onehot_err(err), .wr_count(cnt)
  );

  register_file_32x32 #(.DATA_W(32), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .E(E), .PW(PW), .SA(SA), .SB(SB),
    .PA(PA4), .PB(PB4), .onehot_err(err4), .wr_count(cnt4)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int hot_idx(input logic [31:0] e);
    for (int i = 0; i < 32; i++) if (e[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] sel);
    if (sel == 5'd0) return 32'd0;
    if ($countones(E) == 1 && hot_idx(E) == int'(sel)) return PW;
    return mem[sel];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mem[i] = 32'd0;
    ref_err  = 1'b0;
    ref_cnt  = 0;
    ref_cnt4 = 0;
  endtask

  task automatic model_edge();
    int n;
    n = $countones(E);
    if (n == 1) begin
      if (hot_idx(E) != 0) mem[hot_idx(E)] = PW;
      if (ref_cnt < 65535) ref_cnt++;
      if (ref_cnt4 < 15) ref_cnt4++;
    end else if (n > 1) begin
      ref_err = 1'b1;
    end
  endtask

  task automatic check_outs(input string ph);
    chk({ph, "_pa"},   PA,  ref_read(SA));
    chk({ph, "_pb"},   PB,  ref_read(SB));
    chk({ph, "_pa4"},  PA4, ref_read(SA));
    chk({ph, "_err"},  32'(err),  32'(ref_err));
    chk({ph, "_err4"}, 32'(err4), 32'(ref_err));
    chk({ph, "_cnt"},  32'(cnt),  32'(ref_cnt));
    chk({ph, "_cnt4"}, 32'(cnt4), 32'(ref_cnt4));
  endtask

  task automatic step(input logic [31:0] e, input logic [31:0] pw,
                      input logic [4:0] sa, input logic [4:0] sb);
    @(negedge clk);
    E = e; PW = pw; SA = sa; SB = sb;
    #1 check_outs("pre");
    @(posedge clk);
    model_edge();
    #1 check_outs("post");
  endtask

  // Reset asserted mid-cycle; a write presented while reset is high must be lost.
  task automatic do_reset(input logic [31:0] e_during, input logic [4:0] sa);
    @(negedge clk);
    #2;
    E = '0; SA = sa; SB = sa;
    reset = 1'b1;
    #1;
    model_reset();
    check_outs("rst");
    E = e_during; PW = $urandom;
    @(posedge clk);
    #1;
    @(negedge clk);
    E = '0;
    reset = 1'b0;
    #1 check_outs("rel");
  endtask

  function automatic logic [31:0] rand_e();
    int r;
    logic [31:0] e;
    r = $urandom_range(0, 99);
    if (r < 10) return 32'd0;
    if (r < 15) return 32'd1;
    e = 32'd1 << $urandom_range(1, 31);
    if (r < 88) return e;
    return e | (32'd1 << $urandom_range(0, 31)) | 32'h0000_0003;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e;
    logic [4:0]  sa;
    model_reset();
    #12;
    check_outs("init");
    @(negedge clk);
    reset = 1'b0;

    // R5 written then reset mid-cycle, plus a write attempted during reset.
    step(32'h0000_0020, 32'hDEAD_BEEF, 5'd5, 5'd5);
    do_reset(32'h0000_0020, 5'd5);

    // Every writable register, read back on both ports; the 4-bit counter saturates.
    for (int k = 1; k < 32; k++) step(32'd1 << k, 32'h1234_5678 ^ (32'(k) << 20), 5'(k), 5'(k));
    for (int k = 1; k < 32; k++) step(32'd0, 32'hFFFF_FFFF, 5'(k), 5'(32 - k));

    // $zero write, bypass on both ports, illegal E.
    step(32'h0000_0001, 32'hFFFF_FFFF, 5'd0, 5'd0);
    step(32'h0000_0008, 32'hAAAA_0000, 5'd3, 5'd3);
    step(32'h0000_0008, 32'h5555_FFFF, 5'd3, 5'd3);
    step(32'h0000_0000, 32'h0, 5'd3, 5'd3);
    step(32'h0000_0006, 32'h1111_1111, 5'd1, 5'd2);
    for (int k = 0; k < 10; k++) step(32'd1 << (k + 4), $urandom, 5'd1, 5'd2);
    do_reset(32'h0, 5'd1);

    for (int it = 0; it < 500; it++) begin
      if (it % 60 == 59) do_reset(rand_e(), 5'($urandom));
      e = rand_e();
      sa = ($urandom_range(0, 2) == 0 && hot_idx(e) >= 0) ? 5'(hot_idx(e)) : 5'($urandom);
      step(e, $urandom, sa, 5'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/register_file_32x32.md
# register_file_32x32

Architectural MIPS register file. It sits directly downstream of the 5-to-32 binary decoder and uses the decoder's one-hot enable vector E as its write-port select. Two combinational read ports feed the ID stage. Register $zero is hardwired to 0. Writes commit on the rising clock edge, and same-cycle write-to-read bypass is provided.

## Interface
- `DATA_W`, default 32: register width.
- `CNT_W`, default 16: width of the committed-write counter.

Ports:
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `E`, input, 32: one-hot write enable from the binary decoder. All-zero means no write.
- `PW`, input, DATA_W: write data.
- `SA`, input, 5: read port A register select.
- `SB`, input, 5: read port B register select.
- `PA`, output, DATA_W: read port A data.
- `PB`, output, DATA_W: read port B data.
- `onehot_err`, output, 1: sticky flag; E had more than one bit set on some clock edge.
- `wr_count`, output, CNT_W: saturating count of committed writes.

## Operation
Reset (asserted at any time, takes effect immediately, independent of `clk`):
- R1..R31 = 0.
- `onehot_err` = 0.
- `wr_count` = 0.
- `PA` and `PB` read 0, because all registers are 0.

Write qualification is evaluated each rising edge with `reset` low:
- `E` = 0: no write, no counter change.
- Exactly one bit k set, k ≠ 0: Rk ← PW; `wr_count` += 1, saturating at 2^CNT_W − 1.
- Only bit 0 set: the write is discarded, since $zero is immutable. `wr_count` still increments, because the write was issued legally.
- Two or more bits set: no register changes, `onehot_err` ← 1 (sticky until reset), `wr_count` unchanged.

Reads are combinational on `SA`, `SB`, `E`, `PW` and register contents:
- Select 0 always returns 0.
- Bypass: if `E` is legal one-hot with bit n set, n ≠ 0, and the select equals n, the port returns `PW`.
- Otherwise the port returns the stored register value.
- Both ports may select the same register, and both may bypass in the same cycle.

One-hot legality is computed once and shared by the write logic, the bypass and the error flag.

## Timing
- Read latency: 0 cycles (combinational).
- Write latency: the stored value is visible from the edge it commits on. The same-cycle value is visible earlier via bypass.
- `onehot_err` and `wr_count` update on the same edge as the write decision.
- Reset mid-write: reset wins. A write coinciding with `reset` high is lost.
- Reset release is synchronous to the next rising edge only. The first write can commit on the first edge after `reset` falls.
- Counter at saturation: further legal writes still update registers, and `wr_count` holds at its maximum.
- Illegal `E`: no bypass. Reads return stored values.

## Test plan
1. **Reset:** assert `reset` mid-cycle after writing R5 = 0xDEADBEEF → `PA` (SA = 5) reads 0x00000000 immediately; `wr_count` = 0; `onehot_err` = 0.
2. **Write/read:** E = 0x00000400, PW = 0x12345678, one edge; then E = 0 → with SA = 10, `PA` = 0x12345678 and `wr_count` = 1. Repeat for all 31 writable registers and read each back on both ports.
3. **$zero:** E = 0x00000001, PW = 0xFFFFFFFF, one edge → SA = 0 gives `PA` = 0, no bypass during the write cycle, `wr_count` increments by 1.
4. **Bypass:** R3 = 0xAAAA0000 stored; E = 0x00000008, PW = 0x5555FFFF, SA = SB = 3, before the edge → `PA` = `PB` = 0x5555FFFF; after the edge with E = 0, both still read 0x5555FFFF.
5. **Illegal E:** E = 0x00000006, PW = 0x11111111, SA = 1 → `PA` = old R1 before and after the edge; R1 and R2 unchanged; `onehot_err` = 1 after the edge and remains 1 through 10 legal writes until `reset`.
6. **Saturation:** with CNT_W = 4, perform 20 legal writes → `wr_count` = 15 and holds; the last written register holds the last PW.
